// File: rtl/packet_ev_scheduler_pkg.sv
// Shared definitions for the packet event scheduler: FSM encoding, channel
// limits and the round-robin pointer increment helper.
package pkt_sched_pkg;

  localparam int N_CH_MAX = 8;
  localparam int NCH_W    = 8;
  localparam int IDX_W    = $clog2(N_CH_MAX);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2
  } state_t;

  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] idx, input int n);
    if (int'(idx) >= n - 1) return '0;
    return idx + 1'b1;
  endfunction

endpackage

// File: rtl/packet_ev_scheduler_rr_arbiter.sv
// Combinational round-robin pick: the pending channel closest to the pointer,
// counting upward and wrapping past N_CH-1 to 0.
module rr_arbiter
  import pkt_sched_pkg::*;
#(
  parameter int N_CH = 2
) (
  input  logic [N_CH-1:0]  i_pending,
  input  logic [IDX_W-1:0] i_ptr,
  output logic             o_valid,
  output logic [IDX_W-1:0] o_idx
);

  int w_dist;
  int w_best;

  // Distance from the pointer decides priority; the smallest distance wins.
  always_comb begin
    o_valid = 1'b0;
    o_idx   = '0;
    w_dist  = 0;
    w_best  = N_CH;
    for (int i = 0; i < N_CH; i++) begin
      w_dist = (i >= int'(i_ptr)) ? (i - int'(i_ptr)) : (i + N_CH - int'(i_ptr));
      if (i_pending[i] && (w_dist < w_best)) begin
        w_best  = w_dist;
        o_valid = 1'b1;
        o_idx   = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/packet_ev_scheduler.sv
// Serialises per-channel packet strobes into a one-event-per-clock stream and
// tracks interval numbers between second marks. Option: PKT_EV_SCHED_FIFO_EN.
module packet_ev_scheduler
  import pkt_sched_pkg::*;
#(
  parameter int N_CH    = 2,
  parameter int INTER_W = 16
) (
  input  logic               clk,
  input  logic               clr_n,
  input  logic               run,
  input  logic               pps,
  input  logic               inter_stb,
  input  logic [N_CH-1:0]    req,
  output logic               ev,
  output logic [NCH_W-1:0]   n_ch,
  output logic               cnt_clr,
  output logic [INTER_W-1:0] Numb_inter,
  output logic [N_CH-1:0]    drop,
  output logic               busy
);

  state_t              r_state;
  state_t              w_state_next;
  logic                w_active;
  logic [N_CH-1:0]     w_pend;
  logic [N_CH-1:0]     w_pend_next;
  logic [N_CH-1:0]     w_drop_next;
  logic                w_gnt_valid;
  logic [IDX_W-1:0]    w_gnt_idx;
  logic [IDX_W-1:0]    r_ptr;
  logic                r_ev;
  logic [NCH_W-1:0]    r_n_ch;
  logic                r_cnt_clr;
  logic [INTER_W-1:0]  r_numb;
  logic [N_CH-1:0]     r_drop;
  logic                r_busy;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  // Arbitration only happens in RUN cycles without a second mark.
  always_comb begin
    w_state_next = r_state;
    w_active     = 1'b0;
    case (r_state)
      IDLE:    w_state_next = CLEAR;
      CLEAR:   w_state_next = RUN;
      RUN: begin
        if (pps) w_state_next = CLEAR;
        else     w_active     = 1'b1;
      end
      default: w_state_next = IDLE;
    endcase
    if (!run) begin
      w_state_next = IDLE;
      w_active     = 1'b0;
    end
  end

  rr_arbiter #(.N_CH(N_CH)) u_arb (
    .i_pending (w_pend),
    .i_ptr     (r_ptr),
    .o_valid   (w_gnt_valid),
    .o_idx     (w_gnt_idx)
  );

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    logic w_gnt;
    logic w_drop_ch;
    assign w_gnt = w_gnt_valid && (w_gnt_idx == IDX_W'(gi));
`ifdef PKT_EV_SCHED_FIFO_EN
    logic [1:0] r_cnt;
    logic [1:0] w_cnt_next;

    // A grant frees one slot before the new request is counted.
    always_comb begin
      w_cnt_next = 2'd0;
      w_drop_ch  = 1'b0;
      if (w_active) begin
        w_cnt_next = r_cnt - {1'b0, w_gnt};
        if (req[gi]) begin
          if (w_cnt_next == 2'd2) w_drop_ch  = 1'b1;
          else                    w_cnt_next = w_cnt_next + 2'd1;
        end
      end
    end

    always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) r_cnt <= 2'd0;
      else        r_cnt <= w_cnt_next;
    end

    assign w_pend[gi]      = (r_cnt != 2'd0);
    assign w_pend_next[gi] = (w_cnt_next != 2'd0);
`else
    logic r_bit;
    logic w_bit_next;

    always_comb begin
      w_bit_next = 1'b0;
      w_drop_ch  = 1'b0;
      if (w_active) begin
        w_bit_next = r_bit & ~w_gnt;
        if (req[gi]) begin
          if (w_bit_next) w_drop_ch  = 1'b1;
          else            w_bit_next = 1'b1;
        end
      end
    end

    always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) r_bit <= 1'b0;
      else        r_bit <= w_bit_next;
    end

    assign w_pend[gi]      = r_bit;
    assign w_pend_next[gi] = w_bit_next;
`endif
    assign w_drop_next[gi] = w_drop_ch;
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_ev      <= 1'b0;
      r_n_ch    <= '0;
      r_cnt_clr <= 1'b1;
      r_numb    <= '0;
      r_drop    <= '0;
      r_busy    <= 1'b0;
      r_ptr     <= '0;
    end else begin
      r_ev      <= w_active && w_gnt_valid;
      r_n_ch    <= (w_active && w_gnt_valid) ? NCH_W'(w_gnt_idx) : '0;
      r_cnt_clr <= (w_state_next != RUN);
      r_drop    <= w_drop_next;
      r_busy    <= |w_pend_next;
      if (w_active && w_gnt_valid) r_ptr <= wrap_inc(w_gnt_idx, N_CH);
      // Interval number: zeroed by CLEAR and pps, saturating count otherwise.
      if (r_state == CLEAR) begin
        r_numb <= '0;
      end else if ((r_state == RUN) && run) begin
        if (pps)                                       r_numb <= '0;
        else if (inter_stb && (r_numb != {INTER_W{1'b1}})) r_numb <= r_numb + 1'b1;
      end
    end
  end

  assign ev         = r_ev;
  assign n_ch       = r_n_ch;
  assign cnt_clr    = r_cnt_clr;
  assign Numb_inter = r_numb;
  assign drop       = r_drop;
  assign busy       = r_busy;

endmodule

// File: tb/tb_packet_ev_scheduler.sv
// Self-checking bench for packet_ev_scheduler: directed scenarios plus random
// traffic compared against a counting reference model.
module tb_packet_ev_scheduler;

  localparam int N_CH      = 2;
  localparam int INTER_W   = 16;
  localparam int NUMB_MAX  = (1 << INTER_W) - 1;
`ifdef PKT_EV_SCHED_FIFO_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif
  localparam int PH_IDLE  = 0;
  localparam int PH_CLEAR = 1;
  localparam int PH_RUN   = 2;

  logic               clk = 1'b0;
  logic               clr_n;
  logic               run;
  logic               pps;
  logic               inter_stb;
  logic [N_CH-1:0]    req;
  logic               ev;
  logic [7:0]         n_ch;
  logic               cnt_clr;
  logic [INTER_W-1:0] Numb_inter;
  logic [N_CH-1:0]    drop;
  logic               busy;

  int errors = 0;
  int checks = 0;

  int              m_pend [N_CH];
  int              m_rr;
  int              m_phase;
  int              m_numb;
  logic            m_ev;
  int              m_nch;
  logic [N_CH-1:0] m_drop;
  logic            m_busy;
  logic            m_cnt_clr;

  packet_ev_scheduler #(.N_CH(N_CH), .INTER_W(INTER_W)) dut (
    .clk        (clk),
    .clr_n      (clr_n),
    .run        (run),
    .pps        (pps),
    .inter_stb  (inter_stb),
    .req        (req),
    .ev         (ev),
    .n_ch       (n_ch),
    .cnt_clr    (cnt_clr),
    .Numb_inter (Numb_inter),
    .drop       (drop),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    for (int ch = 0; ch < N_CH; ch++) m_pend[ch] = 0;
    m_rr = 0; m_phase = PH_IDLE; m_numb = 0;
    m_ev = 1'b0; m_nch = 0; m_drop = '0; m_busy = 1'b0; m_cnt_clr = 1'b1;
  endtask

  // One clock of the scheduler's rules, using the inputs present at the edge.
  task automatic model_step();
    int win;
    int nxt;
    m_ev = 1'b0; m_nch = 0; m_drop = '0;
    if (m_phase == PH_RUN && run && !pps) begin
      win = -1;
      for (int off = 0; off < N_CH; off++)
        if (win < 0 && m_pend[(m_rr + off) % N_CH] > 0) win = (m_rr + off) % N_CH;
      if (win >= 0) begin
        m_pend[win] = m_pend[win] - 1;
        m_ev  = 1'b1;
        m_nch = win;
        m_rr  = (win + 1) % N_CH;
      end
      for (int ch = 0; ch < N_CH; ch++)
        if (req[ch]) begin
          if (m_pend[ch] < DEPTH) m_pend[ch] = m_pend[ch] + 1;
          else                    m_drop[ch] = 1'b1;
        end
    end else begin
      for (int ch = 0; ch < N_CH; ch++) m_pend[ch] = 0;
    end
    if (m_phase == PH_CLEAR) m_numb = 0;
    else if (m_phase == PH_RUN && run) begin
      if (pps) m_numb = 0;
      else if (inter_stb && m_numb < NUMB_MAX) m_numb = m_numb + 1;
    end
    if (!run)                    nxt = PH_IDLE;
    else if (m_phase == PH_IDLE) nxt = PH_CLEAR;
    else if (m_phase == PH_CLEAR) nxt = PH_RUN;
    else                         nxt = pps ? PH_CLEAR : PH_RUN;
    m_phase   = nxt;
    m_cnt_clr = (nxt != PH_RUN);
    m_busy    = 1'b0;
    for (int ch = 0; ch < N_CH; ch++) if (m_pend[ch] > 0) m_busy = 1'b1;
  endtask

  task automatic tick(input logic r, input logic p, input logic s, input logic [N_CH-1:0] q);
    run = r; pps = p; inter_stb = s; req = q;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    clr_n = 1'b0; run = 1'b0; pps = 1'b0; inter_stb = 1'b0; req = '0;
    model_reset();
    #23;
    checks++;
    if (ev !== 1'b0 || n_ch !== 8'd0 || cnt_clr !== 1'b1 || Numb_inter !== '0 || drop !== '0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: ev=%b n_ch=%0d cnt_clr=%b numb=%0d drop=%b busy=%b expected 0 0 1 0 0 0",
               ev, n_ch, cnt_clr, Numb_inter, drop, busy);
    end
    @(negedge clk);
    clr_n = 1'b1;
    tick(1'b0, 1'b0, 1'b0, 2'b11);
    checks++;
    if (cnt_clr !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL idle_clr: cnt_clr=%b busy=%b expected 1 0", cnt_clr, busy);
    end
    tick(1'b1, 1'b0, 1'b0, 2'b00);
    checks++;
    if (cnt_clr !== 1'b1 || ev !== 1'b0) begin
      errors++; $display("FAIL clear_cycle: cnt_clr=%b ev=%b expected 1 0", cnt_clr, ev);
    end
    tick(1'b1, 1'b0, 1'b0, 2'b00);
    checks++;
    if (cnt_clr !== 1'b0 || Numb_inter !== '0 || ev !== 1'b0) begin
      errors++; $display("FAIL run_entry: cnt_clr=%b numb=%0d ev=%b expected 0 0 0", cnt_clr, Numb_inter, ev);
    end
  endtask

  task automatic test_single();
    tick(1'b1, 1'b0, 1'b0, 2'b01);
    checks++;
    if (ev !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL single_capture: ev=%b busy=%b expected 0 1", ev, busy);
    end
    tick(1'b1, 1'b0, 1'b0, 2'b00);
    checks++;
    if (ev !== 1'b1 || n_ch !== 8'd0 || busy !== 1'b0 || drop !== '0) begin
      errors++; $display("FAIL single_grant: ev=%b n_ch=%0d busy=%b drop=%b expected 1 0 0 00", ev, n_ch, busy, drop);
    end
    tick(1'b1, 1'b0, 1'b0, 2'b00);
    checks++;
    if (ev !== 1'b0 || n_ch !== 8'd0) begin
      errors++; $display("FAIL single_end: ev=%b n_ch=%0d expected 0 0", ev, n_ch);
    end
  endtask

  task automatic test_back_to_back();
    logic [N_CH-1:0] pre [2];
    int exp_order [2][2];
    pre[0] = 2'b10; pre[1] = 2'b01;
    exp_order[0][0] = 0; exp_order[0][1] = 1;
    exp_order[1][0] = 1; exp_order[1][1] = 0;
    for (int t = 0; t < 2; t++) begin
      tick(1'b1, 1'b0, 1'b0, pre[t]);
      tick(1'b1, 1'b0, 1'b0, 2'b00);
      tick(1'b1, 1'b0, 1'b0, 2'b00);
      tick(1'b1, 1'b0, 1'b0, 2'b11);
      for (int k = 0; k < 2; k++) begin
        tick(1'b1, 1'b0, 1'b0, 2'b00);
        checks++;
        if (ev !== 1'b1 || n_ch !== 8'(exp_order[t][k])) begin
          errors++; $display("FAIL b2b_order t%0d k%0d: ev=%b n_ch=%0d expected 1 %0d", t, k, ev, n_ch, exp_order[t][k]);
        end
      end
      tick(1'b1, 1'b0, 1'b0, 2'b00);
      checks++;
      if (ev !== 1'b0 || busy !== 1'b0) begin
        errors++; $display("FAIL b2b_idle t%0d: ev=%b busy=%b expected 0 0", t, ev, busy);
      end
    end
  endtask

  task automatic test_drop();
    tick(1'b1, 1'b0, 1'b0, 2'b11);
    tick(1'b1, 1'b0, 1'b0, 2'b01);
    checks++;
    if (ev !== 1'b1 || n_ch !== 8'd1 || drop !== ((DEPTH == 1) ? 2'b01 : 2'b00)) begin
      errors++; $display("FAIL drop_pulse: ev=%b n_ch=%0d drop=%b expected 1 1 %b", ev, n_ch, drop,
                         (DEPTH == 1) ? 2'b01 : 2'b00);
    end
    tick(1'b1, 1'b0, 1'b0, 2'b00);
    checks++;
    if (ev !== 1'b1 || n_ch !== 8'd0 || drop !== 2'b00) begin
      errors++; $display("FAIL drop_next: ev=%b n_ch=%0d drop=%b expected 1 0 00", ev, n_ch, drop);
    end
    tick(1'b1, 1'b0, 1'b0, 2'b00);
    checks++;
    if (ev !== ((DEPTH == 2) ? 1'b1 : 1'b0) || n_ch !== 8'd0) begin
      errors++; $display("FAIL drop_depth: ev=%b n_ch=%0d expected %0d 0", ev, n_ch, (DEPTH == 2) ? 1 : 0);
    end
    tick(1'b1, 1'b0, 1'b0, 2'b00);
    checks++;
    if (ev !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL drop_drain: ev=%b busy=%b expected 0 0", ev, busy);
    end
  endtask

  task automatic test_numb_pps();
    for (int k = 1; k <= 3; k++) begin
      tick(1'b1, 1'b0, 1'b1, 2'b00);
      checks++;
      if (Numb_inter !== INTER_W'(k)) begin
        errors++; $display("FAIL numb_count: numb=%0d expected %0d", Numb_inter, k);
      end
    end
    tick(1'b1, 1'b1, 1'b1, 2'b10);
    checks++;
    if (Numb_inter !== '0 || cnt_clr !== 1'b1 || ev !== 1'b0 || drop !== '0 || busy !== 1'b0) begin
      errors++; $display("FAIL pps_edge: numb=%0d cnt_clr=%b ev=%b drop=%b busy=%b expected 0 1 0 00 0",
                         Numb_inter, cnt_clr, ev, drop, busy);
    end
    tick(1'b1, 1'b0, 1'b0, 2'b00);
    checks++;
    if (cnt_clr !== 1'b0 || ev !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL pps_clear: cnt_clr=%b ev=%b busy=%b expected 0 0 0", cnt_clr, ev, busy);
    end
    tick(1'b1, 1'b0, 1'b0, 2'b00);
    checks++;
    if (ev !== 1'b0) begin
      errors++; $display("FAIL pps_no_ev: ev=%b expected 0", ev);
    end
  endtask

  task automatic test_saturate_and_stop();
    for (int k = 0; k < NUMB_MAX; k++) tick(1'b1, 1'b0, 1'b1, 2'b00);
    checks++;
    if (Numb_inter !== 16'hFFFF) begin
      errors++; $display("FAIL numb_full: numb=%h expected ffff", Numb_inter);
    end
    tick(1'b1, 1'b0, 1'b1, 2'b00);
    checks++;
    if (Numb_inter !== 16'hFFFF) begin
      errors++; $display("FAIL numb_saturate: numb=%h expected ffff", Numb_inter);
    end
    tick(1'b1, 1'b0, 1'b0, 2'b11);
    tick(1'b0, 1'b0, 1'b0, 2'b00);
    checks++;
    if (ev !== 1'b0 || busy !== 1'b0 || cnt_clr !== 1'b1) begin
      errors++; $display("FAIL stop_burst: ev=%b busy=%b cnt_clr=%b expected 0 0 1", ev, busy, cnt_clr);
    end
    tick(1'b0, 1'b0, 1'b1, 2'b11);
    checks++;
    if (ev !== 1'b0 || busy !== 1'b0 || Numb_inter !== 16'hFFFF) begin
      errors++; $display("FAIL idle_hold: ev=%b busy=%b numb=%h expected 0 0 ffff", ev, busy, Numb_inter);
    end
    tick(1'b1, 1'b0, 1'b0, 2'b00);
    tick(1'b1, 1'b0, 1'b0, 2'b00);
    checks++;
    if (Numb_inter !== '0 || cnt_clr !== 1'b0) begin
      errors++; $display("FAIL restart: numb=%h cnt_clr=%b expected 0 0", Numb_inter, cnt_clr);
    end
  endtask

  task automatic test_random();
    logic r, p, s;
    logic [N_CH-1:0] q;
    for (int n = 0; n < 3000; n++) begin
      r = ($urandom_range(0, 99) < 97);
      p = ($urandom_range(0, 99) < 3);
      s = ($urandom_range(0, 4) == 0);
      q = N_CH'($urandom) & N_CH'($urandom_range(0, 3));
      tick(r, p, s, q);
      checks++;
      if (ev !== m_ev || n_ch !== 8'(m_nch) || cnt_clr !== m_cnt_clr || Numb_inter !== INTER_W'(m_numb)
          || drop !== m_drop || busy !== m_busy) begin
        errors++;
        $display("FAIL random_cycle %0d: ev=%b n_ch=%0d clr=%b numb=%0d drop=%b busy=%b expected %b %0d %b %0d %b %b",
                 n, ev, n_ch, cnt_clr, Numb_inter, drop, busy, m_ev, m_nch, m_cnt_clr, m_numb, m_drop, m_busy);
      end
      checks++;
      if (ev && cnt_clr) begin
        errors++; $display("FAIL random_ev_clr %0d: ev=%b cnt_clr=%b expected not both 1", n, ev, cnt_clr);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_drop();
    test_numb_pps();
    test_saturate_and_stop();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
